// File: rtl/stream_arb_pkg.sv
// Shared types for the stream arbitration/mux blocks.
// Arbiter FSM state type and select-width helper.
package stream_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int sel_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin pick: first set req bit at or above prio_ptr, wrapping.
// Ports: req, prio_ptr in; found, sel out. Purely combinational.
module rr_priority_select #(
  parameter int NumInputs = 4,
  parameter int SelBits   = 2
) (
  input  logic [NumInputs-1:0] req,
  input  logic [SelBits-1:0]   prio_ptr,
  output logic                 found,
  output logic [SelBits-1:0]   sel
);

  logic [2*NumInputs-1:0] dbl;
  logic [NumInputs-1:0]   rot;
  logic [SelBits-1:0]     off;
  logic [SelBits:0]       sum;

  always_comb begin
    dbl = {req, req};
    // bit k of rot is requester (prio_ptr + k) mod NumInputs
    rot = dbl[prio_ptr +: NumInputs];
    off = '0;
    for (int k = NumInputs - 1; k >= 0; k--) begin
      if (rot[k]) off = SelBits'(k);
    end
    sum = {1'b0, prio_ptr} + {1'b0, off};
    if (sum >= (SelBits+1)'(NumInputs)) begin
      sum = sum - (SelBits+1)'(NumInputs);
    end
    found = |req;
    sel   = sum[SelBits-1:0];
  end

endmodule

// File: rtl/stream_frame_arbiter.sv
// Frame-locked round-robin arbiter onto one ready/valid stream.
// Ports: in_valid/in_ready/in_data/in_eof per source; out_* shared; out_sel.
module stream_frame_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NumInputs = 4,
  parameter int DataBits  = 8,
  localparam int SelBits  = sel_bits(NumInputs)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumInputs-1:0]          in_valid,
  output logic [NumInputs-1:0]          in_ready,
  input  logic [NumInputs*DataBits-1:0] in_data,
  input  logic [NumInputs-1:0]          in_eof,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DataBits-1:0]           out_data,
  output logic                          out_eof,
  output logic [SelBits-1:0]            out_sel
);

  arb_state_e         state_q, state_d;
  logic [SelBits-1:0] grant_q, grant_d;
  logic [SelBits-1:0] prio_q, prio_d;
  logic               found;
  logic [SelBits-1:0] pick;
  logic [DataBits-1:0] data_arr [NumInputs];

  for (genvar i = 0; i < NumInputs; i++) begin : g_split
    assign data_arr[i] = in_data[i*DataBits +: DataBits];
  end

  rr_priority_select #(
    .NumInputs(NumInputs),
    .SelBits  (SelBits)
  ) u_pick (
    .req     (in_valid),
    .prio_ptr(prio_q),
    .found   (found),
    .sel     (pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    prio_d    = prio_q;
    out_valid = 1'b0;
    in_ready  = '0;
    out_data  = data_arr[grant_q];
    out_eof   = in_eof[grant_q];
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        out_valid         = in_valid[grant_q];
        in_ready[grant_q] = out_ready;
        if (in_valid[grant_q] && out_ready && in_eof[grant_q]) begin
          state_d = IDLE;
          // just-served source drops to lowest priority
          prio_d = (grant_q == SelBits'(NumInputs - 1))
                   ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_sel = grant_q;

endmodule

// File: doc/stream_frame_arbiter.md
# stream_frame_arbiter

Round-robin arbiter that shares one downstream ready/valid stream, typically a `stream_deserializer_eof`, between `NumInputs` framed requesters. Once a requester is granted, its whole frame passes through, up to and including the beat with `eof` set, before any other requester is considered. Frames from different requesters therefore never interleave at the output. The block sits between per-source packetizers and the shared deserializer/formatting path.

## Interface
- `NumInputs`, 4: number of requesters; legal range 2..16.
- `DataBits`, 8: data width per beat.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `in_valid` in `NumInputs`: per-requester valid; bit i belongs to requester i.
- `in_ready` out `NumInputs`: per-requester ready.
- `in_data` in `NumInputs*DataBits`: requester i occupies `[i*DataBits +: DataBits]`.
- `in_eof` in `NumInputs`: per-requester end-of-frame; qualified by valid.
- `out_valid` out 1: downstream valid.
- `out_ready` in 1: downstream ready.
- `out_data` out `DataBits`: granted requester's data.
- `out_eof` out 1: granted requester's eof.
- `out_sel` out `SelBits`: index of the current grant; `SelBits` = max(1, clog2(`NumInputs`)).

## Operation
- **State IDLE**
  - All `in_ready`=0 and `out_valid`=0.
  - If any `in_valid` bit is set, pick the first set bit found by scanning upward from `prio_ptr`, wrapping from `NumInputs`-1 to 0.
  - Register that index into `grant` and go to LOCKED.
- **State LOCKED**
  - Pass-through for requester `g` = `grant`: `out_valid`=`in_valid[g]`, `out_data`=`in_data[g]`, `out_eof`=`in_eof[g]`, `in_ready[g]`=`out_ready`.
  - All other `in_ready` bits are 0.
  - A beat transfers when `in_valid[g]` and `out_ready` are both 1.
- **Frame end:** on a transferring beat with `in_eof[g]`=1:
  - go to IDLE;
  - set `prio_ptr` to `g`+1, wrapping to 0 after `NumInputs`-1.
- **Stalls in LOCKED** are not a frame end. Deassertion of `in_valid[g]` or of `out_ready` holds LOCKED indefinitely; there is no timeout.
- **Requester changes in LOCKED:** `in_valid` of other requesters is ignored, and changes to it have no effect on the grant.
- **Single-beat frames** (eof on the first beat) are legal. The requester is granted, sends one beat, and the block returns to IDLE.
- **Zero-width gaps:** the datapath is pure combinational pass-through, so no beat is ever buffered or dropped.
- **`out_sel` and unused data:** `out_sel` equals `grant` in LOCKED and holds its last value in IDLE. `out_data`/`out_eof` are don't-care when `out_valid`=0; the implementation drives them from `in_*[grant]`.

## Timing
- **Reset values:** state=IDLE, `grant`=0, `prio_ptr`=0, `out_sel`=0, `out_valid`=0, all `in_ready`=0.
- **Reset mid-frame:** reset is asynchronous and takes effect immediately. The block drops the frame and after release behaves as freshly reset; upstream and downstream must also be reset.
- **Arbitration latency:** one cycle. Requests visible in IDLE at edge N give LOCKED from edge N, and the first beat can transfer in cycle N+1.
- **Frame-boundary bubble:** every frame boundary costs exactly one IDLE cycle. Sustained throughput is L/(L+1) for frames of L beats.
- **Throughput within a frame:** one beat per cycle.
- **Combinational paths:** `out_ready` to `in_ready[g]`, and `in_valid[g]` to `out_valid`. There is no registered path from `out_ready` back to `out_valid`.
- **Fairness:** the requester just served has lowest priority next round. Any requester holding `in_valid` is granted within `NumInputs`-1 frames.

## Structure
- **Shared package `stream_arb_pkg`:**
  - state type with values IDLE=1'b0, LOCKED=1'b1;
  - a `clog2`-based `SelBits` helper function, reused by other stream muxes.
- **Sub-module `rr_priority_select`:** combinational.
  - Inputs: `NumInputs`-bit request vector and `prio_ptr`.
  - Outputs: `found` flag and the selected index.
  - Implementation: doubled-vector rotate plus a priority encoder.
- **Top level contents:** the FSM, `grant`/`prio_ptr` registers, the output mux and the `in_ready` demux.

## Test plan
- **Reset:**
  - Stimulus: hold `rst`=0 with all `in_valid`=1.
  - Required: `out_valid`=0, `in_ready`=0, `out_sel`=0.
  - Stimulus: release reset.
  - Required: grant to 0 on the first edge, first beat from requester 0 one cycle later.
- **Round-robin:**
  - Stimulus: `NumInputs`=4, all four requesters send 3-beat frames continuously.
  - Required: grant order 0,1,2,3,0; one IDLE cycle between frames; 12 beats in 16 cycles.
- **No interleave:**
  - Stimulus: requester 2 frame of 5 beats with `in_valid[2]` gapped every other cycle, while requester 1 holds valid.
  - Required: all 5 beats from requester 2 appear contiguously before any requester 1 beat; `in_ready[1]` stays 0 throughout.
- **Backpressure:**
  - Stimulus: `out_ready`=0 for 4 cycles mid-frame.
  - Required: `in_ready[g]`=0, data held stable, state stays LOCKED, no beat lost or duplicated (scoreboard compare).
- **Single-beat frames plus wrap:**
  - Stimulus: only requesters 3 and 0 active, eof on every beat.
  - Required: alternating grants 3,0,3,0; `prio_ptr` wraps 3→0 correctly.
- **Async reset mid-frame:**
  - Stimulus: assert `rst` at a random point inside a LOCKED frame.
  - Required: outputs reach reset values without waiting for a clock edge; after release, the next grant follows `prio_ptr`=0.
